// File: rtl/tour_cmd.sv
`timescale 1ns/1ps
// tour_cmd: replays tour_logic's solved knight tour as cmd_proc drive commands.
// Each one-hot move is split into a vertical leg (opcode 2) followed by a
// horizontal leg (opcode 3), each sequenced through cmd_proc's
// ready/clear/response handshake. While idle, UART commands pass straight through.
//
// Optional build macro: TOUR_CMD_CHK_EN
//   When defined, a zero or multi-hot move aborts the tour and pulses tour_err.
//   When undefined, the lowest set bit wins and all-zero decodes as bit 0.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start_tour        one-cycle pulse: begin replaying the tour (ignored unless idle)
//   move              one-hot move for mv_indx, from tour_logic
//   mv_indx           move index driven to tour_logic
//   cmd_UART          UART command, plus cmd_rdy_UART valid / clr_cmd_rdy_UART consume
//   cmd, cmd_rdy      command and valid to cmd_proc
//   clr_cmd_rdy       cmd_proc accepted cmd
//   send_resp         cmd_proc finished executing cmd
//   tour_done         one-cycle pulse after the last move completes
//   tour_err          (TOUR_CMD_CHK_EN only) one-cycle pulse on an illegal move
//
// state  | meaning
// IDLE   | UART pass-through, waiting for start_tour
// LATCH  | capture move for mv_indx
// VERT   | vertical leg offered to cmd_proc
// RESP_V | vertical leg accepted, waiting for send_resp
// HORZ   | horizontal leg offered to cmd_proc
// RESP_H | horizontal leg accepted, waiting for send_resp
module tour_cmd #(
    parameter int NUM_MOVES = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_tour,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    output logic        clr_cmd_rdy_UART,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
`ifdef TOUR_CMD_CHK_EN
    output logic        tour_err,
`endif
    output logic        tour_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_LATCH, S_VERT, S_RESP_V, S_HORZ, S_RESP_H
    } state_t;

    localparam logic [4:0] LAST_IDX = 5'(NUM_MOVES - 1);

    state_t     state_q, state_d;
    logic [4:0] mv_indx_q, mv_indx_d;
    logic [7:0] mv_q, mv_d;
    logic       tour_done_q, tour_done_d;
`ifdef TOUR_CMD_CHK_EN
    logic       tour_err_q, tour_err_d;
`endif

    logic       dy_neg, dx_neg;
    logic [1:0] dy_mag, dx_mag;
    logic [15:0] vert_cmd, horz_cmd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mv_indx_q   <= '0;
            mv_q        <= '0;
            tour_done_q <= 1'b0;
`ifdef TOUR_CMD_CHK_EN
            tour_err_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mv_indx_q   <= mv_indx_d;
            mv_q        <= mv_d;
            tour_done_q <= tour_done_d;
`ifdef TOUR_CMD_CHK_EN
            tour_err_q  <= tour_err_d;
`endif
        end
    end

    // Knight move decode, +y = North, +x = East. Lowest set bit has priority;
    // all-zero falls through to the bit-0 move.
    always_comb begin
        dy_neg = 1'b0; dy_mag = 2'd2; dx_neg = 1'b1; dx_mag = 2'd1;
        if (mv_q[0]) begin
            dy_neg = 1'b0; dy_mag = 2'd2; dx_neg = 1'b1; dx_mag = 2'd1;
        end else if (mv_q[1]) begin
            dy_neg = 1'b0; dy_mag = 2'd2; dx_neg = 1'b0; dx_mag = 2'd1;
        end else if (mv_q[2]) begin
            dy_neg = 1'b1; dy_mag = 2'd1; dx_neg = 1'b1; dx_mag = 2'd2;
        end else if (mv_q[3]) begin
            dy_neg = 1'b0; dy_mag = 2'd1; dx_neg = 1'b1; dx_mag = 2'd2;
        end else if (mv_q[4]) begin
            dy_neg = 1'b1; dy_mag = 2'd2; dx_neg = 1'b1; dx_mag = 2'd1;
        end else if (mv_q[5]) begin
            dy_neg = 1'b1; dy_mag = 2'd2; dx_neg = 1'b0; dx_mag = 2'd1;
        end else if (mv_q[6]) begin
            dy_neg = 1'b0; dy_mag = 2'd1; dx_neg = 1'b0; dx_mag = 2'd2;
        end else if (mv_q[7]) begin
            dy_neg = 1'b1; dy_mag = 2'd1; dx_neg = 1'b0; dx_mag = 2'd2;
        end
    end

    // Headings: N=00, S=7F, W=3F, E=BF.
    assign vert_cmd = {4'h2, (dy_neg ? 8'h7F : 8'h00), 2'b00, dy_mag};
    assign horz_cmd = {4'h3, (dx_neg ? 8'h3F : 8'hBF), 2'b00, dx_mag};

    always_comb begin
        state_d          = state_q;
        mv_indx_d        = mv_indx_q;
        mv_d             = mv_q;
        tour_done_d      = 1'b0;
`ifdef TOUR_CMD_CHK_EN
        tour_err_d       = 1'b0;
`endif
        cmd              = '0;
        cmd_rdy          = 1'b0;
        clr_cmd_rdy_UART = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // The UART command is held off (not dropped) on the start cycle.
                cmd              = cmd_UART;
                cmd_rdy          = cmd_rdy_UART & ~start_tour;
                clr_cmd_rdy_UART = clr_cmd_rdy & ~start_tour;
                if (start_tour) begin
                    mv_indx_d = '0;
                    state_d   = S_LATCH;
                end
            end
            S_LATCH: begin
`ifdef TOUR_CMD_CHK_EN
                if ((move == 8'h00) || ((move & (move - 8'd1)) != 8'h00)) begin
                    tour_err_d = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    mv_d    = move;
                    state_d = S_VERT;
                end
`else
                mv_d    = move;
                state_d = S_VERT;
`endif
            end
            S_VERT: begin
                cmd     = vert_cmd;
                cmd_rdy = 1'b1;
                if (clr_cmd_rdy) state_d = S_RESP_V;
            end
            S_RESP_V: begin
                cmd = vert_cmd;
                if (send_resp) state_d = S_HORZ;
            end
            S_HORZ: begin
                cmd     = horz_cmd;
                cmd_rdy = 1'b1;
                if (clr_cmd_rdy) state_d = S_RESP_H;
            end
            S_RESP_H: begin
                cmd = horz_cmd;
                if (send_resp) begin
                    if (mv_indx_q == LAST_IDX) begin
                        tour_done_d = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        mv_indx_d = mv_indx_q + 5'd1;
                        state_d   = S_LATCH;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign mv_indx   = mv_indx_q;
    assign tour_done = tour_done_q;
`ifdef TOUR_CMD_CHK_EN
    assign tour_err  = tour_err_q;
`endif

endmodule

// File: tb/tb_tour_cmd.sv
`timescale 1ns/1ps
module tb_tour_cmd;

    logic        clk = 1'b0;
    logic        rst_n, start_tour, cmd_rdy_UART, clr_cmd_rdy, send_resp;
    logic [7:0]  move;
    logic [4:0]  mv_indx;
    logic [15:0] cmd_UART, cmd;
    logic        clr_cmd_rdy_UART, cmd_rdy, tour_done;
`ifdef TOUR_CMD_CHK_EN
    logic        tour_err;
`endif
    logic [7:0]  tab [32];

    int checks = 0, errors = 0, hs_cnt = 0, done_cnt = 0;

    always #5 clk = ~clk;

    // Stand-in for tour_logic: combinational move lookup by index.
    assign move = tab[mv_indx];

    always @(posedge clk) if (cmd_rdy && clr_cmd_rdy) hs_cnt++;
    always @(negedge clk) if (tour_done) done_cnt++;

    tour_cmd #(.NUM_MOVES(24)) dut (
        .clk(clk), .rst_n(rst_n), .start_tour(start_tour), .move(move),
        .mv_indx(mv_indx), .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART),
        .clr_cmd_rdy_UART(clr_cmd_rdy_UART), .cmd(cmd), .cmd_rdy(cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp),
`ifdef TOUR_CMD_CHK_EN
        .tour_err(tour_err),
`endif
        .tour_done(tour_done)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Reference leg for a move: dy/dx table, lowest set bit wins, zero -> bit 0.
    function automatic logic [15:0] model_leg(input logic [7:0] m, input bit horiz);
        int b, dy, dx, mag;
        b = 0;
        for (int i = 7; i >= 0; i--) if (m[i]) b = i;
        case (b)
            0: begin dy =  2; dx = -1; end
            1: begin dy =  2; dx =  1; end
            2: begin dy = -1; dx = -2; end
            3: begin dy =  1; dx = -2; end
            4: begin dy = -2; dx = -1; end
            5: begin dy = -2; dx =  1; end
            6: begin dy =  1; dx =  2; end
            default: begin dy = -1; dx = 2; end
        endcase
        if (!horiz) begin
            mag = (dy < 0) ? -dy : dy;
            return {4'h2, (dy > 0) ? 8'h00 : 8'h7F, 4'(mag)};
        end
        mag = (dx < 0) ? -dx : dx;
        return {4'h3, (dx > 0) ? 8'hBF : 8'h3F, 4'(mag)};
    endfunction

    // Plays cmd_proc for one leg: waits for cmd_rdy, captures cmd, then clears and responds.
    task automatic serve_leg(output logic [15:0] c, output bit to, input int d_clr, input int d_resp);
        int n;
        n = 0; to = 1'b0;
        while (cmd_rdy !== 1'b1 && n < 200) begin @(negedge clk); #1; n++; end
        if (n >= 200) begin to = 1'b1; c = 16'hxxxx; return; end
        c = cmd;
        repeat (d_clr) @(negedge clk);
        clr_cmd_rdy = 1'b1; @(posedge clk); #1; clr_cmd_rdy = 1'b0;
        repeat (d_resp) @(negedge clk);
        send_resp = 1'b1; @(posedge clk); #1; send_resp = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start_tour = 0; cmd_rdy_UART = 0; clr_cmd_rdy = 0; send_resp = 0;
        cmd_UART = '0;
        for (int i = 0; i < 32; i++) tab[i] = 8'h02;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
    endtask

    task automatic pulse_start();
        @(negedge clk); start_tour = 1'b1; @(posedge clk); #1; start_tour = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0; #1;
        checks++; if (mv_indx !== 5'd0) begin errors++; $display("FAIL reset_mv_indx: got %0d expected 0", mv_indx); end
        checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL reset_cmd_rdy: got %b expected 0", cmd_rdy); end
        checks++; if (tour_done !== 1'b0) begin errors++; $display("FAIL reset_tour_done: got %b expected 0", tour_done); end
        rst_n = 1'b1; @(negedge clk); #1;
    endtask

    task automatic test_passthrough();
        do_reset();
        cmd_UART = 16'h2BF3; cmd_rdy_UART = 1'b1; clr_cmd_rdy = 1'b1; #1;
        checks++; if (cmd !== 16'h2BF3) begin errors++; $display("FAIL pass_cmd: got %h expected 2bf3", cmd); end
        checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL pass_rdy: got %b expected 1", cmd_rdy); end
        checks++; if (clr_cmd_rdy_UART !== 1'b1) begin errors++; $display("FAIL pass_clr: got %b expected 1", clr_cmd_rdy_UART); end
        clr_cmd_rdy = 1'b0; cmd_rdy_UART = 1'b0; #1;
        checks++; if (clr_cmd_rdy_UART !== 1'b0) begin errors++; $display("FAIL pass_clr_low: got %b expected 0", clr_cmd_rdy_UART); end
        checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL pass_rdy_low: got %b expected 0", cmd_rdy); end
    endtask

    task automatic test_single_move();
        logic [15:0] c; bit to;
        do_reset();
        @(negedge clk); start_tour = 1'b1; cmd_UART = 16'h2BF3; cmd_rdy_UART = 1'b1; #1;
        checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL start_uart_ignored: got %b expected 0", cmd_rdy); end
        @(posedge clk); #1; start_tour = 1'b0;
        checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL latch_rdy: got %b expected 0", cmd_rdy); end
        @(posedge clk); #1;
        checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL n2_rdy: got %b expected 1", cmd_rdy); end
        checks++; if (cmd !== 16'h2002) begin errors++; $display("FAIL n2_cmd: got %h expected 2002", cmd); end
        clr_cmd_rdy = 1'b1; #1;
        checks++; if (clr_cmd_rdy_UART !== 1'b0) begin errors++; $display("FAIL tour_uart_clr: got %b expected 0", clr_cmd_rdy_UART); end
        @(posedge clk); #1; clr_cmd_rdy = 1'b0;
        checks++; if (cmd_rdy !== 1'b0 || cmd !== 16'h2002) begin errors++; $display("FAIL resp_v_hold: got rdy=%b cmd=%h expected 0/2002", cmd_rdy, cmd); end
        send_resp = 1'b1; @(posedge clk); #1; send_resp = 1'b0;
        checks++; if (cmd !== 16'h3BF1 || cmd_rdy !== 1'b1) begin errors++; $display("FAIL horz_leg: got rdy=%b cmd=%h expected 1/3bf1", cmd_rdy, cmd); end
        serve_leg(c, to, 0, 0);
        checks++; if (to) begin errors++; $display("FAIL horz_serve: got timeout expected handshake"); end
        checks++; if (mv_indx !== 5'd1) begin errors++; $display("FAIL next_index: got %0d expected 1", mv_indx); end
        cmd_rdy_UART = 1'b0;
    endtask

    task automatic test_decode();
        logic [15:0] c; bit to;
        logic [15:0] exp_legs [4];
        exp_legs[0] = 16'h27F1; exp_legs[1] = 16'h33F2; exp_legs[2] = 16'h27F1; exp_legs[3] = 16'h3BF2;
        do_reset();
        tab[0] = 8'h04; tab[1] = 8'h80;
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            serve_leg(c, to, i, 3 - i);
            checks++; if (to || c !== exp_legs[i]) begin errors++; $display("FAIL decode_leg%0d: got %h expected %h", i, c, exp_legs[i]); end
        end
        checks++; if (mv_indx !== 5'd2) begin errors++; $display("FAIL decode_index: got %0d expected 2", mv_indx); end
    endtask

    task automatic test_full_tour();
        logic [15:0] c, e; bit to;
        do_reset();
        for (int i = 0; i < 24; i++) tab[i] = 8'h01 << $urandom_range(0, 7);
        hs_cnt = 0; done_cnt = 0;
        pulse_start();
        for (int i = 0; i < 24; i++) begin
            for (int h = 0; h < 2; h++) begin
                e = model_leg(tab[i], h[0]);
                serve_leg(c, to, $urandom_range(0, 20), $urandom_range(0, 20));
                checks++; if (to || c !== e) begin errors++; $display("FAIL tour_move%0d_leg%0d: got %h expected %h", i, h, c, e); end
                if (i < 23 || h == 0) begin
                    checks++; if (tour_done !== 1'b0) begin errors++; $display("FAIL tour_done_early: got 1 expected 0 at move %0d", i); end
                end
            end
        end
        checks++; if (tour_done !== 1'b1) begin errors++; $display("FAIL tour_done_pulse: got %b expected 1", tour_done); end
        checks++; if (mv_indx !== 5'd23) begin errors++; $display("FAIL tour_last_index: got %0d expected 23", mv_indx); end
        @(posedge clk); #1;
        checks++; if (tour_done !== 1'b0) begin errors++; $display("FAIL tour_done_width: got %b expected 0", tour_done); end
        checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL tour_idle_rdy: got %b expected 0", cmd_rdy); end
        repeat (3) @(negedge clk); #1;
        checks++; if (mv_indx !== 5'd23) begin errors++; $display("FAIL tour_index_hold: got %0d expected 23", mv_indx); end
        checks++; if (hs_cnt !== 48) begin errors++; $display("FAIL tour_handshakes: got %0d expected 48", hs_cnt); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL tour_done_count: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_edges();
        logic [15:0] c; bit to;
        do_reset();
        pulse_start();
        serve_leg(c, to, 0, 0);
        serve_leg(c, to, 0, 0);
        @(posedge clk); #1;
        checks++; if (cmd_rdy !== 1'b1 || mv_indx !== 5'd1) begin errors++; $display("FAIL edge_vert: got rdy=%b idx=%0d expected 1/1", cmd_rdy, mv_indx); end
        clr_cmd_rdy = 1'b1; send_resp = 1'b1; @(posedge clk); #1; clr_cmd_rdy = 1'b0; send_resp = 1'b0;
        repeat (3) @(negedge clk); #1;
        checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL early_resp_ignored: got rdy=%b expected 0", cmd_rdy); end
        start_tour = 1'b1; @(posedge clk); #1; start_tour = 1'b0;
        repeat (2) @(negedge clk); #1;
        checks++; if (cmd_rdy !== 1'b0 || mv_indx !== 5'd1) begin errors++; $display("FAIL start_mid_ignored: got rdy=%b idx=%0d expected 0/1", cmd_rdy, mv_indx); end
        send_resp = 1'b1; @(posedge clk); #1; send_resp = 1'b0;
        checks++; if (cmd_rdy !== 1'b1 || cmd !== 16'h3BF1) begin errors++; $display("FAIL edge_horz: got rdy=%b cmd=%h expected 1/3bf1", cmd_rdy, cmd); end
        @(negedge clk); rst_n = 1'b0; #1;
        checks++; if (cmd_rdy !== 1'b0 || mv_indx !== 5'd0) begin errors++; $display("FAIL async_abort: got rdy=%b idx=%0d expected 0/0", cmd_rdy, mv_indx); end
        @(negedge clk); rst_n = 1'b1; @(negedge clk); #1;
    endtask

    task automatic test_non_onehot();
        logic [15:0] c; bit to;
        do_reset();
        tab[0] = 8'h01; tab[1] = 8'h02; tab[2] = 8'h04; tab[3] = 8'h08; tab[4] = 8'h10; tab[5] = 8'h03;
        done_cnt = 0;
        pulse_start();
        for (int i = 0; i < 10; i++) serve_leg(c, to, 0, 0);
        checks++; if (mv_indx !== 5'd5) begin errors++; $display("FAIL bad_index: got %0d expected 5", mv_indx); end
`ifdef TOUR_CMD_CHK_EN
        checks++; if (tour_err !== 1'b0) begin errors++; $display("FAIL err_early: got %b expected 0", tour_err); end
        @(posedge clk); #1;
        checks++; if (tour_err !== 1'b1 || cmd_rdy !== 1'b0 || mv_indx !== 5'd5) begin errors++; $display("FAIL err_pulse: got err=%b rdy=%b idx=%0d expected 1/0/5", tour_err, cmd_rdy, mv_indx); end
        @(posedge clk); #1;
        checks++; if (tour_err !== 1'b0 || tour_done !== 1'b0 || done_cnt !== 0) begin errors++; $display("FAIL err_after: got err=%b done=%b expected 0/0", tour_err, tour_done); end
        cmd_UART = 16'h2BF3; cmd_rdy_UART = 1'b1; #1;
        checks++; if (cmd_rdy !== 1'b1 || cmd !== 16'h2BF3) begin errors++; $display("FAIL err_idle: got rdy=%b cmd=%h expected 1/2bf3", cmd_rdy, cmd); end
        cmd_rdy_UART = 1'b0;
`else
        serve_leg(c, to, 0, 0);
        checks++; if (to || c !== 16'h2002) begin errors++; $display("FAIL multihot_vert: got %h expected 2002", c); end
        serve_leg(c, to, 0, 0);
        checks++; if (to || c !== 16'h33F1) begin errors++; $display("FAIL multihot_horz: got %h expected 33f1", c); end
`endif
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_single_move();
        test_decode();
        test_full_tour();
        test_edges();
        test_non_onehot();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tour_cmd.md
Name: tour_cmd

Overview:
- Sits directly downstream of tour_logic and upstream of cmd_proc.
- Walks tour_logic's solved move list by index and splits each one-hot knight move into two drive commands: a vertical leg, then a horizontal leg.
- Sequences each command through the cmd_proc ready/clear/response handshake.
- When no tour is running, passes UART commands straight through to cmd_proc.

Parameters:
- NUM_MOVES, 24, moves in a full tour (5x5 board); legal range 1..32.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- start_tour  in  1  one-cycle pulse: begin replaying the solved tour
- move  in  8  one-hot move from tour_logic for index mv_indx (combinational there)
- mv_indx  out  5  index driven to tour_logic
- cmd_UART  in  16  command from UART wrapper
- cmd_rdy_UART  in  1  UART command valid
- clr_cmd_rdy_UART  out  1  consume strobe back to UART wrapper
- cmd  out  16  command to cmd_proc
- cmd_rdy  out  1  command valid to cmd_proc
- clr_cmd_rdy  in  1  cmd_proc accepted cmd
- send_resp  in  1  cmd_proc finished executing cmd
- tour_done  out  1  one-cycle pulse when last move completes

Reset: rst_n is asynchronous and active-low; the clock is clk.
- All registers clear on reset: state=IDLE, mv_indx=0, mv_q=0, tour_done=0.

Behaviour:
Command format:
- [15:12] opcode: 4'h2 = move, 4'h3 = move with fanfare.
- [11:4] heading: N=8'h00, W=8'h3F, S=8'h7F, E=8'hBF.
- [3:0] squares.
- Vertical leg always uses opcode 2; horizontal leg always uses opcode 3.

Move decode (bit: dy, dx), +y=N, +x=E:
- b0: +2,-1
- b1: +2,+1
- b2: -1,-2
- b3: +1,-2
- b4: -2,-1
- b5: -2,+1
- b6: +1,+2
- b7: -1,+2

State machine:
- IDLE: cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, clr_cmd_rdy_UART=clr_cmd_rdy. On start_tour: mv_indx<=0, go to LATCH; cmd_rdy_UART is ignored that cycle.
- LATCH (1 cycle): mv_q<=move, go to VERT.
- VERT: cmd=vertical leg of mv_q, cmd_rdy=1. On clr_cmd_rdy, go to RESP_V.
- RESP_V: cmd_rdy=0. On send_resp, go to HORZ.
- HORZ: cmd=horizontal leg of mv_q, cmd_rdy=1. On clr_cmd_rdy, go to RESP_H.
- RESP_H: on send_resp:
  - if mv_indx==NUM_MOVES-1: go to IDLE and set tour_done=1 for the next cycle.
  - else: mv_indx<=mv_indx+1, go to LATCH.

Outside IDLE:
- clr_cmd_rdy_UART=0; UART commands stay pending and are not dropped.
- start_tour is ignored.
- cmd holds the current leg's value in RESP states.

Timing and handshake rules:
- Latency: start_tour at cycle N gives LATCH at N+1 and cmd_rdy=1 at N+2.
- send_resp is honoured only in RESP_V and RESP_H. A send_resp arriving in VERT/HORZ (including the same cycle as clr_cmd_rdy) is ignored.
- mv_indx holds its last value after the tour; it is cleared only by the next start_tour.
- Async reset mid-tour aborts immediately to IDLE with cmd_rdy=0.
- The decode of a non-one-hot move is governed by the optional feature.

Optional Feature:
Macro: TOUR_CMD_CHK_EN
- Defined: in LATCH, if move is zero or multi-hot, the block:
  - drives no command;
  - goes to IDLE;
  - pulses output tour_err (1 bit, reset 0) high for one cycle;
  - leaves mv_indx at the failing index;
  - does not pulse tour_done.
- Undefined: tour_err port is absent; the lowest set bit wins; all-zero decodes as b0.

Test Plan:
1. IDLE pass-through: cmd_UART=16'h2BF3, cmd_rdy_UART=1, then clr_cmd_rdy=1 -> cmd=16'h2BF3, cmd_rdy=1, clr_cmd_rdy_UART=1 in the same cycle.
2. move=8'h02 at index 0, start_tour -> cmd=16'h2002 with cmd_rdy at N+2; after clr+resp, cmd=16'h3BF1; after clr+resp, mv_indx=1.
3. move=8'h04 -> legs 16'h27F1 then 16'h33F2. move=8'h80 -> legs 16'h27F1 then 16'h3BF2.
4. Full 24-move tour with random clr/resp delays (0-20 cycles) -> exactly 48 cmd_rdy handshakes, tour_done high exactly one cycle after the final send_resp, mv_indx=23.
5. Edge cases:
   - send_resp asserted together with clr_cmd_rdy in VERT -> FSM stays in RESP_V until a later send_resp.
   - start_tour mid-tour -> ignored.
   - rst_n low during HORZ -> cmd_rdy=0 and mv_indx=0 immediately.
6. With TOUR_CMD_CHK_EN, move=8'h03 at index 5 -> tour_err pulses, state IDLE, mv_indx=5, no cmd_rdy. Without the macro -> legs decode as b0 (16'h2002, 16'h33F1).
